clk_div_checker: RTL and testbench

Measures a divided clock produced elsewhere in the clk_in domain (e.g. the /2, /4, /8 outputs of the even divider). For each rising edge of the monitored signal, the block reports:
- the period and high time, both in clk_in cycles;
- whether the duty cycle is exactly 50%;
- lock status after a run of identical periods.

It sits beside the divider as the self-check and receive side of the divided-clock interface. Errors and loss of signal are flagged with single-cycle pulses.

---
 rtl/clk_div_checker_if.sv | 23 ++
 rtl/clk_div_checker.sv | 141 ++++++++++++++
 tb/tb_clk_div_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_checker_if.sv
// Divided-clock link: the divider drives clk_div, the checker returns its measurements.
interface clk_div_if #(
  parameter int CNT_W = 8
);
  logic             clk_div;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             duty_ok;
  logic             locked;
  logic             err;
  logic             lost;

  modport master (
    output clk_div,
    input  period, high_time, meas_valid, duty_ok, locked, err, lost
  );

  modport slave (
    input  clk_div,
    output period, high_time, meas_valid, duty_ok, locked, err, lost
  );
endinterface

// File: rtl/clk_div_checker.sv
// Measures period, high time, duty and lock of a divided clock sampled in the clk_in domain.
// Loss of signal and period changes while locked are flagged with one-cycle pulses.
module clk_div_checker #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic     clk_in,
  input  logic     rst,
  clk_div_if.slave div_if
);
  localparam int              MW     = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] MAXC   = '1;
  localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_N);

  typedef enum logic {S_IDLE, S_MEAS} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_d1;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_hi_lat;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic [MW-1:0]    r_match_cnt;
  logic [MW-1:0]    w_match_next;
  logic             r_first;
  logic             r_meas_valid;
  logic             r_duty_ok;
  logic             r_locked;
  logic             r_err;
  logic             r_lost;
  logic             w_rise;
  logic             w_fall;
  logic             w_arm;
  logic             w_publish;
  logic             w_timeout;
  logic             w_per_same;
  logic             w_duty_next;

  assign w_rise = div_if.clk_div & ~r_d1;
  assign w_fall = ~div_if.clk_div & r_d1;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_state_next = S_MEAS;
      S_MEAS:  if (!w_rise && (r_per_cnt == MAXC)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A rise coinciding with a saturated period counter publishes rather than timing out.
  always_comb begin
    w_arm     = 1'b0;
    w_publish = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: w_arm = w_rise;
      S_MEAS: begin
        w_publish = w_rise;
        w_timeout = ~w_rise & (r_per_cnt == MAXC);
      end
      default: ;
    endcase
    w_per_same = (r_per_cnt == r_period);
    if (r_first || !w_per_same)       w_match_next = MW'(1);
    else if (r_match_cnt == LOCK_C)   w_match_next = LOCK_C;
    else                              w_match_next = r_match_cnt + 1'b1;
    w_duty_next = ({r_hi_lat, 1'b0} == {1'b0, r_per_cnt});
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_d1         <= 1'b0;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_hi_lat     <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_match_cnt  <= '0;
      r_first      <= 1'b0;
      r_meas_valid <= 1'b0;
      r_duty_ok    <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      r_d1         <= div_if.clk_div;
      r_meas_valid <= 1'b0;
      r_err        <= 1'b0;
      r_lost       <= 1'b0;

      if (w_rise) begin
        r_per_cnt <= CNT_W'(1);
        r_hi_cnt  <= CNT_W'(1);
      end else if (r_state == S_MEAS) begin
        if (r_per_cnt != MAXC)                     r_per_cnt <= r_per_cnt + 1'b1;
        if (div_if.clk_div && (r_hi_cnt != MAXC))  r_hi_cnt  <= r_hi_cnt + 1'b1;
      end

      if ((r_state == S_MEAS) && w_fall) r_hi_lat <= r_hi_cnt;

      if (w_arm) begin
        r_match_cnt <= '0;
        r_first     <= 1'b1;
      end

      if (w_publish) begin
        r_period     <= r_per_cnt;
        r_high_time  <= r_hi_lat;
        r_duty_ok    <= w_duty_next;
        r_meas_valid <= 1'b1;
        r_match_cnt  <= w_match_next;
        r_locked     <= (w_match_next == LOCK_C);
        r_err        <= r_locked & ~w_per_same;
        r_first      <= 1'b0;
      end

      if (w_timeout) begin
        r_lost      <= 1'b1;
        r_locked    <= 1'b0;
        r_match_cnt <= '0;
        r_duty_ok   <= 1'b0;
      end
    end
  end

  assign div_if.period     = r_period;
  assign div_if.high_time  = r_high_time;
  assign div_if.meas_valid = r_meas_valid;
  assign div_if.duty_ok    = r_duty_ok;
  assign div_if.locked     = r_locked;
  assign div_if.err        = r_err;
  assign div_if.lost       = r_lost;
endmodule

// File: tb/tb_clk_div_checker.sv
// Drives directed clk_div waveforms; expected publishes and loss events go through a queue.
module tb_clk_div_checker;
  localparam int MAXC = 255;

  logic clk_in;
  logic rst;
  int   cyc;
  int   nchk;
  int   nerr;

  typedef struct {
    bit is_lost;
    int cyc;
    int per;
    int hi;
    bit duty;
    bit lock;
    bit err;
  } exp_t;

  exp_t q[$];

  clk_div_if #(.CNT_W(8)) dif ();

  clk_div_checker #(.CNT_W(8), .LOCK_N(4)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    nchk++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},     int'(dif.period),     0);
    chk({tag, "_high_time"},  int'(dif.high_time),  0);
    chk({tag, "_meas_valid"}, int'(dif.meas_valid), 0);
    chk({tag, "_duty_ok"},    int'(dif.duty_ok),    0);
    chk({tag, "_locked"},     int'(dif.locked),     0);
    chk({tag, "_err"},        int'(dif.err),        0);
    chk({tag, "_lost"},       int'(dif.lost),       0);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One clk_div period starting with a rise: h cycles high, l cycles low.
  task automatic seg(input int h, input int l, input bit pub, input int per, input int hi,
                     input bit duty, input bit lock, input bit err, input bit lost_exp);
    exp_t e;
    dif.clk_div = 1'b1;
    if (pub) begin
      e = '{is_lost: 1'b0, cyc: cyc + 1, per: per, hi: hi, duty: duty, lock: lock, err: err};
      q.push_back(e);
    end
    if (lost_exp) begin
      e = '{is_lost: 1'b1, cyc: cyc + MAXC + 1, per: per, hi: hi, duty: 1'b0, lock: 1'b0, err: 1'b0};
      q.push_back(e);
    end
    repeat (h) step();
    dif.clk_div = 1'b0;
    repeat (l) step();
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      nchk++;
      nerr++;
      $display("FAIL missing_event: lost=%0d expected at cycle %0d, not observed by cycle %0d",
               e.is_lost, e.cyc, cyc);
    end
    if (dif.err && !dif.meas_valid) begin
      nchk++;
      nerr++;
      $display("FAIL stray_err: err=1 without meas_valid at cycle %0d", cyc);
    end
    if (dif.meas_valid || dif.lost) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_event: meas_valid=%0d lost=%0d at cycle %0d, nothing expected",
                 dif.meas_valid, dif.lost, cyc);
      end else begin
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_kind", int'({dif.meas_valid, dif.lost}), e.is_lost ? 1 : 2);
        chk("period",     int'(dif.period),    e.per);
        chk("high_time",  int'(dif.high_time), e.hi);
        chk("duty_ok",    int'(dif.duty_ok),   int'(e.duty));
        chk("locked",     int'(dif.locked),    int'(e.lock));
        chk("err",        int'(dif.err),       int'(e.err));
      end
    end
  end

  initial begin
    nchk = 0;
    nerr = 0;
    rst = 1'b0;
    dif.clk_div = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (3) step();

    // /2 : lock on the 4th publish
    seg(1, 1, 0, 0, 0, 0, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 1, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 1, 0, 0);
    // /8 (4 high / 4 low): change from period 2 errs, then relocks
    seg(4, 4, 1, 2, 1, 1, 1, 0, 0);
    seg(4, 4, 1, 8, 4, 1, 0, 1, 0);
    seg(4, 4, 1, 8, 4, 1, 0, 0, 0);
    seg(4, 4, 1, 8, 4, 1, 0, 0, 0);
    seg(4, 4, 1, 8, 4, 1, 1, 0, 0);
    seg(4, 4, 1, 8, 4, 1, 1, 0, 0);
    // /4: one err on the first period-4 publish, relock after 4
    seg(2, 2, 1, 8, 4, 1, 1, 0, 0);
    seg(2, 2, 1, 4, 2, 1, 0, 1, 0);
    seg(2, 2, 1, 4, 2, 1, 0, 0, 0);
    seg(2, 2, 1, 4, 2, 1, 0, 0, 0);
    seg(2, 2, 1, 4, 2, 1, 1, 0, 0);
    seg(2, 2, 1, 4, 2, 1, 1, 0, 0);
    // period 6, high 2: duty_ok low but lock still acquired
    seg(2, 4, 1, 4, 2, 1, 1, 0, 0);
    seg(2, 4, 1, 6, 2, 0, 0, 1, 0);
    seg(2, 4, 1, 6, 2, 0, 0, 0, 0);
    seg(2, 4, 1, 6, 2, 0, 0, 0, 0);
    seg(2, 4, 1, 6, 2, 0, 1, 0, 0);
    seg(2, 4, 1, 6, 2, 0, 1, 0, 0);
    // stuck low for 300 cycles: lost pulse, period/high_time hold
    seg(2, 300, 1, 6, 2, 0, 1, 0, 1);
    // re-arm is silent; a 255-cycle period publishes MAXC instead of timing out
    seg(1, 254, 0, 0, 0, 0, 0, 0, 0);
    seg(1, 1, 1, 255, 1, 0, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 1, 0, 0);
    seg(3, 3, 1, 2, 1, 1, 1, 0, 0);
    seg(3, 3, 1, 6, 3, 1, 0, 1, 0);
    seg(3, 3, 1, 6, 3, 1, 0, 0, 0);
    seg(3, 3, 1, 6, 3, 1, 0, 0, 0);
    seg(3, 3, 1, 6, 3, 1, 1, 0, 0);
    seg(3, 3, 1, 6, 3, 1, 1, 0, 0);

    // asynchronous reset mid-period while locked
    chk("locked_before_rst", int'(dif.locked), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    step();
    rst = 1'b1;
    // rise in the first cycle after release; only the second rise publishes
    seg(1, 1, 0, 0, 0, 0, 0, 0, 0);
    seg(1, 1, 1, 2, 1, 1, 0, 0, 0);
    repeat (10) step();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    nchk++;
    nerr++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
